// File: rtl/sd_spi_responder.sv
// SD-card side of SPI-mode block read/write: decodes 6-byte commands, answers
// R1 and data tokens, and serves block data from a byte-wide synchronous memory.
module sd_spi_responder #(
    parameter int BLOCK_SIZE = 512,
    parameter int ADDR_WIDTH = 16,
    parameter int NCR        = 1,
    parameter int BUSY_BYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cs,
    input  logic                  sclk,
    input  logic                  mosi,
    output logic                  miso,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [7:0]            mem_rdata,
    output logic [7:0]            mem_wdata,
    output logic                  mem_we,
    output logic [7:0]            debug
);
    localparam int OFF_BITS = $clog2(BLOCK_SIZE);
    localparam int BLK_BITS = ADDR_WIDTH - OFF_BITS;
    localparam logic [31:0] BLOCKS = 32'(1) << BLK_BITS;
    localparam int CNT_W = 16;

    typedef enum logic [3:0] {
        ST_CMD_WAIT = 4'd0,  ST_CMD_RX   = 4'd1,  ST_NCR_GAP  = 4'd2,
        ST_R1       = 4'd3,  ST_RD_GAP   = 4'd4,  ST_RD_TOKEN = 4'd5,
        ST_RD_DATA  = 4'd6,  ST_RD_CRC   = 4'd7,  ST_WR_TOKEN = 4'd8,
        ST_WR_DATA  = 4'd9,  ST_WR_CRC   = 4'd10, ST_WR_RESP  = 4'd11,
        ST_WR_BUSY  = 4'd12
    } state_t;

    logic [1:0]            r_cs_sync;
    logic [2:0]            r_sclk_sync;
    logic [1:0]            r_mosi_sync;
    logic                  w_cs_high, w_rise, w_fall, w_mosi;
    logic [2:0]            r_bit_cnt;
    logic [6:0]            r_rx;
    logic [7:0]            r_tx;
    logic                  r_miso;
    logic                  w_byte_done;
    logic [7:0]            w_rx_byte;
    state_t                r_state, w_state_nxt;
    logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
    logic [7:0]            w_tx_nxt;
    logic [5:0]            r_idx;
    logic [31:0]           r_arg;
    logic [7:0]            r_r1, w_r1;
    logic                  r_idle, w_idle_nxt, r_prev55, w_arg_ok;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [7:0]            r_mem_wdata;
    logic                  r_mem_we;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cs_sync   <= 2'b11;
            r_sclk_sync <= 3'b000;
            r_mosi_sync <= 2'b11;
        end else begin
            r_cs_sync   <= {r_cs_sync[0], cs};
            r_sclk_sync <= {r_sclk_sync[1:0], sclk};
            r_mosi_sync <= {r_mosi_sync[0], mosi};
        end
    end

    assign w_cs_high   = r_cs_sync[1];
    assign w_rise      = r_sclk_sync[1] & ~r_sclk_sync[2];
    assign w_fall      = ~r_sclk_sync[1] & r_sclk_sync[2];
    assign w_mosi      = r_mosi_sync[1];
    // Deselect masks completion so an abort always wins over a finishing byte.
    assign w_byte_done = ~w_cs_high & w_rise & (r_bit_cnt == 3'd7);
    assign w_rx_byte   = {r_rx, w_mosi};

    always_ff @(posedge clk) begin
        if (rst || w_cs_high) begin
            r_bit_cnt <= 3'd0;
            r_rx      <= 7'd0;
            r_tx      <= 8'hFF;
            r_miso    <= 1'b1;
        end else if (w_rise) begin
            r_rx      <= {r_rx[5:0], w_mosi};
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
                r_tx <= w_tx_nxt;
            end
        end else if (w_fall) begin
            r_miso <= r_tx[7];
            r_tx   <= {r_tx[6:0], 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (rst || w_cs_high) begin
            r_state <= ST_CMD_WAIT;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_tx_nxt    = 8'hFF;
        w_arg_ok    = (r_arg < BLOCKS);
        w_idle_nxt  = r_idle;
        case (r_idx)
            6'd0:         begin w_idle_nxt = 1'b1; w_r1 = 8'h01; end
            6'd55, 6'd16: w_r1 = {7'b0, r_idle};
            6'd41: begin
                if (r_prev55) begin
                    w_idle_nxt = 1'b0;
                    w_r1       = 8'h00;
                end else begin
                    w_r1 = {5'b0, 1'b1, 1'b0, r_idle};
                end
            end
            6'd17, 6'd24: w_r1 = w_arg_ok ? {7'b0, r_idle} : {1'b0, 1'b1, 5'b0, r_idle};
            default:      w_r1 = {5'b0, 1'b1, 1'b0, r_idle};
        endcase
        if (w_byte_done) begin
            case (r_state)
                ST_CMD_WAIT: if (w_rx_byte[7:6] == 2'b01) begin
                    w_state_nxt = ST_CMD_RX;
                    w_cnt_nxt   = '0;
                end
                ST_CMD_RX: begin
                    w_cnt_nxt = r_cnt + 1'b1;
                    if (r_cnt == CNT_W'(4)) begin
                        w_state_nxt = ST_NCR_GAP;
                        w_cnt_nxt   = '0;
                    end
                end
                ST_NCR_GAP: begin
                    w_cnt_nxt = r_cnt + 1'b1;
                    if (r_cnt == CNT_W'(NCR - 1)) begin
                        w_state_nxt = ST_R1;
                        w_tx_nxt    = r_r1;
                        w_cnt_nxt   = '0;
                    end
                end
                ST_R1: begin
                    if (r_idx == 6'd17 && !r_r1[6])      w_state_nxt = ST_RD_GAP;
                    else if (r_idx == 6'd24 && !r_r1[6]) w_state_nxt = ST_WR_TOKEN;
                    else                                 w_state_nxt = ST_CMD_WAIT;
                end
                ST_RD_GAP: begin
                    w_state_nxt = ST_RD_TOKEN;
                    w_tx_nxt    = 8'hFE;
                end
                ST_RD_TOKEN: begin
                    w_state_nxt = ST_RD_DATA;
                    w_tx_nxt    = mem_rdata;
                    w_cnt_nxt   = '0;
                end
                ST_RD_DATA: begin
                    if (r_cnt == CNT_W'(BLOCK_SIZE - 1)) begin
                        w_state_nxt = ST_RD_CRC;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_tx_nxt  = mem_rdata;
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                ST_RD_CRC: begin
                    w_cnt_nxt = r_cnt + 1'b1;
                    if (r_cnt == CNT_W'(1)) w_state_nxt = ST_CMD_WAIT;
                end
                ST_WR_TOKEN: if (w_rx_byte == 8'hFE) begin
                    w_state_nxt = ST_WR_DATA;
                    w_cnt_nxt   = '0;
                end
                ST_WR_DATA: begin
                    w_cnt_nxt = r_cnt + 1'b1;
                    if (r_cnt == CNT_W'(BLOCK_SIZE - 1)) begin
                        w_state_nxt = ST_WR_CRC;
                        w_cnt_nxt   = '0;
                    end
                end
                ST_WR_CRC: begin
                    w_cnt_nxt = r_cnt + 1'b1;
                    if (r_cnt == CNT_W'(1)) begin
                        w_state_nxt = ST_WR_RESP;
                        w_tx_nxt    = 8'h05;
                        w_cnt_nxt   = '0;
                    end
                end
                ST_WR_RESP: begin
                    w_state_nxt = ST_WR_BUSY;
                    w_tx_nxt    = 8'h00;
                    w_cnt_nxt   = '0;
                end
                ST_WR_BUSY: begin
                    if (r_cnt == CNT_W'(BUSY_BYTES - 1)) begin
                        w_state_nxt = ST_CMD_WAIT;
                    end else begin
                        w_tx_nxt  = 8'h00;
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                default: w_state_nxt = ST_CMD_WAIT;
            endcase
        end
    end

    // Command effects land on the CRC byte; memory address advances right after each tx load.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx       <= 6'd0;
            r_arg       <= 32'd0;
            r_r1        <= 8'hFF;
            r_idle      <= 1'b1;
            r_prev55    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= 8'd0;
            r_mem_we    <= 1'b0;
        end else begin
            r_mem_we <= 1'b0;
            if (w_byte_done) begin
                case (r_state)
                    ST_CMD_WAIT: if (w_rx_byte[7:6] == 2'b01) r_idx <= w_rx_byte[5:0];
                    ST_CMD_RX: begin
                        if (r_cnt == CNT_W'(4)) begin
                            r_r1       <= w_r1;
                            r_idle     <= w_idle_nxt;
                            r_prev55   <= (r_idx == 6'd55);
                            r_mem_addr <= {r_arg[BLK_BITS-1:0], {OFF_BITS{1'b0}}};
                        end else begin
                            r_arg <= {r_arg[23:0], w_rx_byte};
                        end
                    end
                    ST_RD_TOKEN, ST_RD_DATA: r_mem_addr <= r_mem_addr + 1'b1;
                    ST_WR_DATA: begin
                        r_mem_we    <= 1'b1;
                        r_mem_wdata <= w_rx_byte;
                        r_mem_addr  <= {r_mem_addr[ADDR_WIDTH-1:OFF_BITS], r_cnt[OFF_BITS-1:0]};
                    end
                    default: ;
                endcase
            end
        end
    end

    assign miso      = r_miso;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_we    = r_mem_we;
    assign debug     = {4'b0, r_state};
endmodule

// File: doc/sd_spi_responder.md
# sd_spi_responder

SD-card-side SPI-mode responder: the target end of the block-read/block-write protocol driven by the team's SD SPI host. Decodes 6-byte SD commands arriving on SPI mode 0, answers with R1 and data tokens, and backs block data with a byte-wide synchronous memory port. It replaces a physical SD card in simulation and on-board loopback tests of the autotest flow.

## Interface
- `BLOCK_SIZE`, 512: bytes per block; power of two.
- `ADDR_WIDTH`, 16: byte-address width of the backing memory; valid blocks are 0 .. 2^ADDR_WIDTH/BLOCK_SIZE-1.
- `NCR`, 1: number of 0xFF bytes sent between command end and R1; range 1..8.
- `BUSY_BYTES`, 4: number of 0x00 busy bytes after a write data response.
- `clk` in 1: system clock.
- `rst` in 1: reset, synchronous, active-high.
- `cs` in 1: SPI chip select, active low.
- `sclk` in 1: SPI clock, mode 0, period ≥ 8 `clk` cycles.
- `mosi` in 1: host-to-card data, MSB first.
- `miso` out 1: card-to-host data; driven 1 whenever no byte is being shifted.
- `mem_addr` out ADDR_WIDTH: byte address to backing memory.
- `mem_rdata` in 8: read data, valid one `clk` after `mem_addr`.
- `mem_wdata` out 8: write data.
- `mem_we` out 1: one-cycle write strobe.
- `debug` out 8: {4'b0, state code}.

## Operation
- `cs`, `sclk`, `mosi` pass through 2-FF synchronizers; sclk rising/falling edges detected on synchronized value.
- Byte layer: while `cs`=0, each rising edge shifts `mosi` into rx register; 8th rising edge yields rx_byte and loads next tx byte. `miso` = tx[7] at the falling edge after byte start, shifting on each falling edge. When `cs` rises: bit counter cleared, tx byte := 0xFF, FSM → CMD_WAIT (abort any transfer; partial write bytes already written stay written).
- FSM states: CMD_WAIT, CMD_RX, NCR_GAP, R1, RD_GAP, RD_TOKEN, RD_DATA, RD_CRC, WR_TOKEN, WR_DATA, WR_CRC, WR_RESP, WR_BUSY.
- CMD_WAIT: tx 0xFF; byte with bits[7:6]=01 → CMD_RX storing index=bits[5:0]. Other bytes ignored.
- CMD_RX: collect 4 argument bytes (MSB first) + 1 CRC byte (CRC not checked) → NCR_GAP, send NCR × 0xFF → R1.
- idle flag: 1 after reset; set by CMD0; cleared by CMD41 when previous command was CMD55. R1 bit0 = idle flag after command effect.
- Responses: CMD0 → 0x01. CMD55 → {7'b0,idle}. CMD41 → 0x00 if preceded by CMD55, else 0x04|idle. CMD16 → {7'b0,idle}, no effect. CMD17/CMD24 with arg < block count → {7'b0,idle}; arg ≥ block count → 0x40|idle, back to CMD_WAIT. Any other index → 0x04|idle.
- Read (CMD17): after R1, one 0xFF (RD_GAP), token 0xFE, BLOCK_SIZE data bytes from byte address arg×BLOCK_SIZE ascending, two 0xFF CRC bytes, → CMD_WAIT. Next byte fetched right after current byte is loaded into tx register.
- Write (CMD24): after R1, WR_TOKEN sends 0xFF and waits for rx 0xFE (other bytes ignored); WR_DATA writes each rx byte: `mem_we` pulses one cycle with incrementing address; 2 CRC bytes ignored; WR_RESP sends 0x05; WR_BUSY sends BUSY_BYTES × 0x00; → CMD_WAIT (tx 0xFF).
- Bytes received during response/read phases are ignored (host sends 0xFF).

## Timing
- Reset values: `miso`=1, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `debug`=0, idle flag=1, FSM=CMD_WAIT.
- sclk edge to internal detection: 3 `clk` max; `miso` updated ≤ 3 `clk` after falling edge, stable before next rising edge given period ≥ 8 `clk`.
- `mem_we` asserted ≤ 4 `clk` after the 8th rising edge of a data byte.
- Memory read issued ≥ 4 `clk` before the byte is needed.
- Block address arithmetic: byte address = arg[ADDR_WIDTH-1-log2(BLOCK_SIZE):0] concatenated with byte offset; range check on full 32-bit arg.
- Simultaneous `cs` rise and byte completion: abort wins; byte discarded.

## Test plan
- CMD0 (0x40 00000000 0x95) then 0xFF clocks → NCR×0xFF then R1 0x01; `miso`=1 while `cs`=1.
- CMD55 → 0x01; CMD41 → 0x00; following CMD16 → 0x00; CMD41 alone → 0x04|idle.
- CMD24 arg=2, token 0xFE, bytes i&0xFF for i=0..511, CRC 0xFFFF → R1 0x00, response 0x05, 4×0x00, memory bytes 1024..1535 written, 512 `mem_we` pulses.
- CMD17 arg=2 → R1 0x00, 0xFF, 0xFE, 512 bytes matching written pattern, 0xFF 0xFF.
- CMD17 arg=128 (ADDR_WIDTH=16) → R1 0x40, no token, FSM back in CMD_WAIT.
- `cs` raised after 100 data bytes of CMD17, then CMD58 → R1 0x04, `debug` shows CMD_WAIT between.
